// File: rtl/ber_sweep_ctrl.sv
// rtl/ber_sweep_ctrl.sv - BER sweep frame/SNR sequencer around ldpc_core
module ber_sweep_ctrl #(
  parameter logic [3:0]        SNR_FIRST  = 4'd0,
  parameter logic [3:0]        SNR_LAST   = 4'd15,
  parameter logic signed [4:0] FRAC_W     = -5'sd1,
  parameter int                FRM_W      = 16,
  parameter int                ERR_W      = 12,
  parameter int                MAX_FRAMES = 1000,
  parameter int                MAX_ERRS   = 100,
  parameter int                TMO_W      = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    buf_full,
  output logic                    buf_clr,
  output logic                    dec_load,
  output logic                    dec_rst,
  output logic                    dec_en,
  input  logic                    dec_term,
  input  logic                    dec_err,
  output logic [3:0]              snr_idx,
  output logic signed [4:0]       frac_w,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3:0]              res_snr,
  output logic [FRM_W-1:0]        res_frames,
  output logic [ERR_W-1:0]        res_errs,
  output logic                    res_tmo,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_LOAD, S_DECODE, S_ACCUM, S_REPORT, S_DONE
  } state_t;

  state_t            state;
  logic [FRM_W-1:0]  frames;
  logic [ERR_W-1:0]  errs;
  logic [TMO_W-1:0]  wd;
  logic              tmo;
  logic              err_q;
  logic              clr_d;

  logic [FRM_W-1:0]  frm_nxt;
  logic [ERR_W-1:0]  err_nxt;
  logic [TMO_W-1:0]  wd_inc;
  logic              close_pt;

  assign frac_w   = FRAC_W;
  assign frm_nxt  = (&frames) ? frames : frames + FRM_W'(1);
  assign err_nxt  = (&errs) ? errs : errs + ERR_W'(err_q);
  assign wd_inc   = wd + TMO_W'(1);
  assign close_pt = (int'(frm_nxt) == MAX_FRAMES) || (int'(err_nxt) >= MAX_ERRS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      frames     <= '0;
      errs       <= '0;
      wd         <= '0;
      tmo        <= 1'b0;
      err_q      <= 1'b0;
      clr_d      <= 1'b0;
      snr_idx    <= SNR_FIRST;
      buf_clr    <= 1'b0;
      dec_load   <= 1'b0;
      dec_rst    <= 1'b1;
      dec_en     <= 1'b0;
      res_valid  <= 1'b0;
      res_snr    <= '0;
      res_frames <= '0;
      res_errs   <= '0;
      res_tmo    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      buf_clr  <= 1'b0;
      dec_load <= 1'b0;
      clr_d    <= buf_clr;
      if (abort) begin
        state     <= S_IDLE;
        dec_rst   <= 1'b1;
        dec_en    <= 1'b0;
        res_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            dec_rst <= 1'b1;
            dec_en  <= 1'b0;
            if (start) begin
              frames  <= '0;
              errs    <= '0;
              tmo     <= 1'b0;
              snr_idx <= SNR_FIRST;
              buf_clr <= 1'b1;
              done    <= 1'b0;
              busy    <= 1'b1;
              state   <= S_FILL;
            end
          end
          S_FILL: begin
            // Buffer flags lag a clear by a cycle, so they are not trusted
            // while the clear pulse is out or during the cycle after it.
            if (buf_full && !buf_clr && !clr_d) begin
              dec_load <= 1'b1;
              buf_clr  <= 1'b1;
              wd       <= '0;
              state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            dec_rst <= 1'b0;
            dec_en  <= 1'b1;
            state   <= S_DECODE;
          end
          S_DECODE: begin
            wd <= wd_inc;
            if (dec_term) begin
              err_q   <= dec_err;
              dec_en  <= 1'b0;
              dec_rst <= 1'b1;
              state   <= S_ACCUM;
            end else if (&wd_inc) begin
              err_q   <= 1'b1;
              tmo     <= 1'b1;
              dec_en  <= 1'b0;
              dec_rst <= 1'b1;
              state   <= S_ACCUM;
            end
          end
          S_ACCUM: begin
            frames <= frm_nxt;
            errs   <= err_nxt;
            if (close_pt) begin
              res_snr    <= snr_idx;
              res_frames <= frm_nxt;
              res_errs   <= err_nxt;
              res_tmo    <= tmo;
              res_valid  <= 1'b1;
              state      <= S_REPORT;
            end else begin
              state <= S_FILL;
            end
          end
          S_REPORT: begin
            if (res_valid && res_ready) begin
              res_valid <= 1'b0;
              if (snr_idx == SNR_LAST) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                // LLRs generated at the old SNR are discarded.
                snr_idx <= snr_idx + 4'd1;
                frames  <= '0;
                errs    <= '0;
                tmo     <= 1'b0;
                buf_clr <= 1'b1;
                state   <= S_FILL;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// tb/tb_ber_sweep_ctrl.sv - randomized self-checking bench for ber_sweep_ctrl
module tb_ber_sweep_ctrl;

  localparam int SF   = 1;
  localparam int SL   = 3;
  localparam int MAXF = 4;
  localparam int MAXE = 2;
  localparam int TMO  = 15;

  typedef struct {
    int snr;
    int frames;
    int errs;
    bit tmo;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, start, abort, buf_full, dec_term, dec_err, res_ready;
  logic              buf_clr, dec_load, dec_rst, dec_en, res_valid, res_tmo, busy, done;
  logic [3:0]        snr_idx, res_snr;
  logic signed [4:0] frac_w;
  logic [7:0]        res_frames;
  logic [3:0]        res_errs;

  ber_sweep_ctrl #(
    .SNR_FIRST(4'(SF)), .SNR_LAST(4'(SL)), .FRAC_W(-5'sd3), .FRM_W(8), .ERR_W(4),
    .MAX_FRAMES(MAXF), .MAX_ERRS(MAXE), .TMO_W(4)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .buf_full(buf_full),
    .buf_clr(buf_clr), .dec_load(dec_load), .dec_rst(dec_rst), .dec_en(dec_en),
    .dec_term(dec_term), .dec_err(dec_err), .snr_idx(snr_idx), .frac_w(frac_w),
    .res_valid(res_valid), .res_ready(res_ready), .res_snr(res_snr),
    .res_frames(res_frames), .res_errs(res_errs), .res_tmo(res_tmo),
    .busy(busy), .done(done)
  );

  int vec = 0;
  int miss = 0;
  int plan_lat[$];
  bit plan_err[$];
  int en_lens[$];
  int fill_lat = 10;
  int fcnt = 0;
  bit stale = 1'b0;
  int cur_lat = 0;
  bit cur_e = 1'b0;
  int k = 0;
  bit prev_en = 1'b0;
  int n_load = 0;
  int n_clr = 0;

  // Environment: buffer bank with stale flags after a clear, and a decoder
  // that terminates on the plan's latency (0 = never terminates).
  initial begin
    buf_full = 1'b0;
    dec_term = 1'b0;
    dec_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (buf_clr === 1'b1) begin
        fcnt = 0; stale = 1'b1; n_clr++;
      end else if (stale) begin
        stale = 1'b0;
      end else begin
        if (fcnt < 1000) fcnt++;
        buf_full = (fcnt >= fill_lat);
      end
      if (dec_load === 1'b1) begin
        n_load++;
        k = 0;
        if (plan_lat.size() > 0) begin
          cur_lat = plan_lat.pop_front();
          cur_e   = plan_err.pop_front();
        end else begin
          cur_lat = 3; cur_e = 1'b0;
        end
      end
      if (prev_en && dec_en !== 1'b1) en_lens.push_back(k);
      prev_en  = (dec_en === 1'b1);
      dec_term = 1'b0;
      dec_err  = 1'($urandom);
      if (dec_en === 1'b1) begin
        k++;
        if (cur_lat != 0 && k == cur_lat) begin
          dec_term = 1'b1;
          dec_err  = cur_e;
        end
      end
    end
  end

  task automatic gen_plan(input int n, input bit all_err);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      plan_lat.push_back(r == 0 ? 0 : (r == 1 ? TMO : $urandom_range(1, TMO - 1)));
      plan_err.push_back(all_err ? 1'b1 : ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic run_sweep(input int hold_max, input bit early);
    res_t exp[$];
    res_t e1;
    int   idx, total, cnt, hold, lat;
    bit   ferr;
    idx = 0;
    for (int s = SF; s <= SL; s++) begin
      e1.snr = s; e1.frames = 0; e1.errs = 0; e1.tmo = 1'b0;
      do begin
        lat  = (idx < plan_lat.size()) ? plan_lat[idx] : 3;
        ferr = (idx < plan_err.size()) ? plan_err[idx] : 1'b0;
        idx++;
        e1.frames++;
        if (lat >= 1 && lat <= TMO) e1.errs += int'(ferr);
        else begin e1.errs++; e1.tmo = 1'b1; end
      end while (!(e1.frames == MAXF || e1.errs >= MAXE));
      exp.push_back(e1);
    end
    total  = idx;
    n_load = 0;
    n_clr  = 0;
    res_ready = early;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    vec++;
    if (busy !== 1'b1 || done !== 1'b0 || buf_clr !== 1'b1 || snr_idx !== 4'(SF)) begin
      miss++;
      $display("FAIL start_entry: busy=%b done=%b buf_clr=%b snr_idx=%0d, want 1 0 1 %0d",
               busy, done, buf_clr, snr_idx, SF);
    end
    for (int r = 0; r < exp.size(); r++) begin
      cnt = 0;
      while (res_valid !== 1'b1 && cnt < 4000) begin @(negedge clk); cnt++; end
      vec++;
      if (res_valid !== 1'b1) begin
        miss++;
        $display("FAIL report_wait[%0d]: res_valid=%b after %0d cycles, want 1", r, res_valid, cnt);
        res_ready = 1'b0;
        return;
      end
      vec++;
      if (res_snr !== 4'(exp[r].snr) || res_frames !== 8'(exp[r].frames) ||
          res_errs !== 4'(exp[r].errs) || res_tmo !== exp[r].tmo) begin
        miss++;
        $display("FAIL result[%0d]: snr=%0d frames=%0d errs=%0d tmo=%b, want %0d %0d %0d %b",
                 r, res_snr, res_frames, res_errs, res_tmo,
                 exp[r].snr, exp[r].frames, exp[r].errs, exp[r].tmo);
      end
      if (!early) begin
        hold = $urandom_range(0, hold_max);
        repeat (hold) begin
          @(negedge clk);
          vec++;
          if (res_valid !== 1'b1 || res_snr !== 4'(exp[r].snr) || res_frames !== 8'(exp[r].frames) ||
              res_errs !== 4'(exp[r].errs) || res_tmo !== exp[r].tmo || snr_idx !== 4'(exp[r].snr)) begin
            miss++;
            $display("FAIL hold_stable[%0d]: valid=%b snr=%0d frames=%0d errs=%0d idx=%0d, want 1 %0d %0d %0d %0d",
                     r, res_valid, res_snr, res_frames, res_errs, snr_idx,
                     exp[r].snr, exp[r].frames, exp[r].errs, exp[r].snr);
          end
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
      if (!early) res_ready = 1'b0;
      vec++;
      if (res_valid !== 1'b0) begin
        miss++;
        $display("FAIL valid_drop[%0d]: res_valid=%b, want 0", r, res_valid);
      end
      vec++;
      if (r < exp.size() - 1) begin
        if (snr_idx !== 4'(exp[r].snr + 1) || buf_clr !== 1'b1 || busy !== 1'b1) begin
          miss++;
          $display("FAIL snr_step[%0d]: snr_idx=%0d buf_clr=%b busy=%b, want %0d 1 1",
                   r, snr_idx, buf_clr, busy, exp[r].snr + 1);
        end
      end else if (done !== 1'b1 || busy !== 1'b0 || snr_idx !== 4'(SL)) begin
        miss++;
        $display("FAIL sweep_done: done=%b busy=%b snr_idx=%0d, want 1 0 %0d", done, busy, snr_idx, SL);
      end
    end
    @(negedge clk);
    res_ready = 1'b0;
    vec++;
    if (n_load != total || done !== 1'b1) begin
      miss++;
      $display("FAIL load_count: dec_load pulses=%0d done=%b, want %0d 1", n_load, done, total);
    end
    vec++;
    if (n_clr != 1 + total + (SL - SF)) begin
      miss++;
      $display("FAIL clr_count: buf_clr pulses=%0d, want %0d", n_clr, 1 + total + (SL - SF));
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (buf_clr !== 1'b0 || dec_load !== 1'b0 || dec_en !== 1'b0 || dec_rst !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0 || snr_idx !== 4'(SF)) begin
      miss++;
      $display("FAIL reset_ctrl: clr=%b load=%b en=%b rst=%b busy=%b done=%b idx=%0d, want 0 0 0 1 0 0 %0d",
               buf_clr, dec_load, dec_en, dec_rst, busy, done, snr_idx, SF);
    end
    vec++;
    if (res_valid !== 1'b0 || res_snr !== 4'd0 || res_frames !== 8'd0 || res_errs !== 4'd0 ||
        res_tmo !== 1'b0 || frac_w !== 5'b11101) begin
      miss++;
      $display("FAIL reset_res: valid=%b snr=%0d frames=%0d errs=%0d tmo=%b frac_w=%b, want 0 0 0 0 0 11101",
               res_valid, res_snr, res_frames, res_errs, res_tmo, frac_w);
    end
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (busy !== 1'b0 || dec_rst !== 1'b1 || buf_clr !== 1'b0) begin
      miss++;
      $display("FAIL idle_hold: busy=%b dec_rst=%b buf_clr=%b, want 0 1 0", busy, dec_rst, buf_clr);
    end
  endtask

  task automatic test_basic;
    plan_lat.delete(); plan_err.delete();
    fill_lat = 10;
    plan_lat = '{10, 10, 10, 10};
    plan_err = '{1'b0, 1'b1, 1'b0, 1'b0};
    gen_plan(16, 1'b0);
    run_sweep(0, 1'b0);
  endtask

  task automatic test_early_close;
    plan_lat.delete(); plan_err.delete();
    fill_lat = $urandom_range(1, 12);
    for (int i = 0; i < 12; i++) begin
      plan_lat.push_back($urandom_range(1, TMO - 1));
      plan_err.push_back(1'b1);
    end
    run_sweep(5, 1'b0);
  endtask

  task automatic test_timeout;
    plan_lat.delete(); plan_err.delete();
    fill_lat = 4;
    plan_lat = '{0, TMO, TMO, 5, TMO, TMO, TMO, TMO, TMO, 0};
    plan_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en_lens.delete();
    run_sweep(3, 1'b0);
    vec++;
    if (en_lens.size() < 4 || en_lens[0] != TMO || en_lens[1] != TMO || en_lens[3] != 5) begin
      miss++;
      $display("FAIL decode_len: n=%0d first=%0d second=%0d fourth=%0d, want %0d %0d 5",
               en_lens.size(), en_lens.size() > 0 ? en_lens[0] : -1,
               en_lens.size() > 1 ? en_lens[1] : -1, en_lens.size() > 3 ? en_lens[3] : -1, TMO, TMO);
    end
  endtask

  task automatic test_backpressure;
    plan_lat.delete(); plan_err.delete();
    fill_lat = $urandom_range(1, 12);
    gen_plan(20, 1'b0);
    run_sweep(50, 1'b0);
  endtask

  task automatic test_back_to_back;
    plan_lat.delete(); plan_err.delete();
    fill_lat = 1;
    gen_plan(20, 1'b0);
    run_sweep(0, 1'b1);
  endtask

  task automatic test_start_busy_abort;
    int cnt;
    plan_lat.delete(); plan_err.delete();
    plan_lat = '{0, 0};
    plan_err = '{1'b0, 1'b0};
    fill_lat = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    while (dec_en !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    vec++;
    if (busy !== 1'b1 || dec_en !== 1'b1 || buf_clr !== 1'b0 || snr_idx !== 4'(SF)) begin
      miss++;
      $display("FAIL start_busy: busy=%b dec_en=%b buf_clr=%b idx=%0d, want 1 1 0 %0d",
               busy, dec_en, buf_clr, snr_idx, SF);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    vec++;
    if (busy !== 1'b0 || dec_en !== 1'b0 || dec_rst !== 1'b1 || res_valid !== 1'b0 || done !== 1'b0) begin
      miss++;
      $display("FAIL abort_decode: busy=%b en=%b rst=%b valid=%b done=%b, want 0 0 1 0 0",
               busy, dec_en, dec_rst, res_valid, done);
    end
    plan_lat.delete(); plan_err.delete();
    gen_plan(8, 1'b1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || cnt >= 2000) begin
      miss++;
      $display("FAIL abort_report: valid=%b busy=%b wait=%0d, want 0 0 <2000", res_valid, busy, cnt);
    end
  endtask

  task automatic test_async_reset;
    int cnt;
    plan_lat.delete(); plan_err.delete();
    fill_lat = 2;
    gen_plan(8, 1'b0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    #2 rstn = 1'b0;
    #1;
    vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || dec_rst !== 1'b1 || snr_idx !== 4'(SF) ||
        res_frames !== 8'd0 || cnt >= 2000) begin
      miss++;
      $display("FAIL async_reset: valid=%b busy=%b rst=%b idx=%0d frames=%0d wait=%0d, want 0 0 1 %0d 0 <2000",
               res_valid, busy, dec_rst, snr_idx, res_frames, cnt, SF);
    end
    @(negedge clk) rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_early_close();
    test_timeout();
    test_backpressure();
    test_start_busy_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
